// File: rtl/axis_switch_pkg.sv
// Shared switch-datapath definitions: buffer mode encoding and pointer sizing.
package axis_switch_pkg;

  typedef enum logic {
    AXIS_CUT_THROUGH = 1'b0,
    AXIS_STORE_FWD   = 1'b1
  } axis_buf_mode_e;

  // Address bits plus one wrap bit, so full and empty can be told apart.
  function automatic int axis_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage for axis_buffer_fifo: synchronous write, asynchronous read, no reset.
module axis_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axis_buffer_fifo.sv
// AXI-Stream circular FIFO with fill level and optional store-and-forward gating.
module axis_buffer_fifo
  import axis_switch_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_USER_WIDTH = 10,
  parameter int T_ID_WIDTH   = 8,
  parameter int PACKET_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [T_ID_WIDTH-1:0]   s_id_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_USER_WIDTH-1:0] s_user_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_ID_WIDTH-1:0]   m_id_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_USER_WIDTH-1:0] m_user_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = axis_ptr_w(DEPTH);
  localparam axis_buf_mode_e MODE = (PACKET_MODE != 0) ? AXIS_STORE_FWD : AXIS_CUT_THROUGH;

  // counted marks a last beat that incremented the packet count, so only it decrements.
  typedef struct packed {
    logic [T_ID_WIDTH-1:0]   id;
    logic [T_DATA_WIDTH-1:0] data;
    logic [T_USER_WIDTH-1:0] user;
    logic                    last;
    logic                    counted;
  } beat_t;

  localparam int BW = $bits(beat_t);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_level;
  logic [PW-1:0] r_pkt_cnt;
  logic          r_flush;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_push_counted;
  logic          w_pop_counted;
  beat_t         w_wr_beat;
  beat_t         w_rd_beat;
  logic [BW-1:0] w_rd_vec;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign s_ready_o = !w_full;
  assign m_valid_o = !w_empty &&
                     ((MODE == AXIS_CUT_THROUGH) || (r_pkt_cnt != '0) || r_flush);

  assign w_push = s_valid_i & s_ready_o;
  assign w_pop  = m_valid_o & m_ready_i;

  assign w_wr_beat.id      = s_id_i;
  assign w_wr_beat.data    = s_data_i;
  assign w_wr_beat.user    = s_user_i;
  assign w_wr_beat.last    = s_last_i;
  assign w_wr_beat.counted = (MODE == AXIS_STORE_FWD) && s_last_i && !r_flush;

  assign w_rd_beat      = beat_t'(w_rd_vec);
  assign w_push_counted = w_push & w_wr_beat.counted;
  assign w_pop_counted  = w_pop & w_rd_beat.last & w_rd_beat.counted;

  axis_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (BW)
  ) u_mem (
    .i_clk     (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (w_wr_beat),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_vec)
  );

  assign m_id_o   = w_rd_beat.id;
  assign m_data_o = w_rd_beat.data;
  assign m_user_o = w_rd_beat.user;
  assign m_last_o = w_rd_beat.last;
  assign level_o  = r_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_pkt_cnt <= '0;
      r_flush   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + PW'(1);
        2'b01:   r_level <= r_level - PW'(1);
        default: r_level <= r_level;
      endcase

      if (w_push_counted && !w_pop_counted) begin
        r_pkt_cnt <= r_pkt_cnt + PW'(1);
      end else if (!w_push_counted && w_pop_counted) begin
        r_pkt_cnt <= r_pkt_cnt - PW'(1);
      end

      // A full buffer with no complete packet can never release one: fall back to cut-through.
      if (MODE == AXIS_STORE_FWD) begin
        if (w_pop && w_rd_beat.last) begin
          r_flush <= 1'b0;
        end else if (w_full && (r_pkt_cnt == '0)) begin
          r_flush <= 1'b1;
        end
      end
    end
  end

endmodule
